// File: rtl/gpio_bank_if.sv
// PicoSoC iomem bus bundle between the CPU-side master and a memory-mapped peripheral.
interface gpio_bank_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/gpio_bank.sv
// WIDTH-channel GPIO on the iomem bus: OUT/DIR registers, synchronised inputs,
// per-bit edge capture into sticky W1C status, and a level interrupt.
module gpio_bank #(
  parameter int         WIDTH       = 8,
  parameter logic [7:0] BASE_ADDR   = 8'h03,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  gpio_bank_if.slave       bus,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam int              CNT_W     = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] QUAL_DONE = CNT_W'(SYNC_STAGES + 1);

  localparam logic [7:0] OFF_OUT    = 8'h00;
  localparam logic [7:0] OFF_IN     = 8'h04;
  localparam logic [7:0] OFF_DIR    = 8'h08;
  localparam logic [7:0] OFF_RISE   = 8'h0C;
  localparam logic [7:0] OFF_FALL   = 8'h10;
  localparam logic [7:0] OFF_STATUS = 8'h14;

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old,
                                             input logic [WIDTH-1:0] data,
                                             input logic [WIDTH-1:0] mask);
    return (old & ~mask) | (data & mask);
  endfunction

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [CNT_W-1:0] qual_cnt;
  logic [WIDTH-1:0] out_q, dir_q, rise_en_q, fall_en_q, status_q;

  logic             sel, wr, qualified;
  logic [7:0]       offset;
  logic [31:0]      strb_mask, rd_mux;
  logic [WIDTH-1:0] wmask, wdata, sync_last, rise, fall, set_bits, clr_bits;
  logic             unused_bits;

  assign sel       = bus.iomem_valid && !bus.iomem_ready && (bus.iomem_addr[31:24] == BASE_ADDR);
  assign wr        = sel && (bus.iomem_wstrb != 4'b0000);
  assign offset    = bus.iomem_addr[7:0];
  assign strb_mask = {{8{bus.iomem_wstrb[3]}}, {8{bus.iomem_wstrb[2]}},
                      {8{bus.iomem_wstrb[1]}}, {8{bus.iomem_wstrb[0]}}};
  assign wmask     = strb_mask[WIDTH-1:0];
  assign wdata     = bus.iomem_wdata[WIDTH-1:0];
  assign unused_bits = ^{bus.iomem_addr[23:8], bus.iomem_wdata, strb_mask};

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign qualified = (qual_cnt == QUAL_DONE);
  assign rise      = sync_last & ~prev_q;
  assign fall      = ~sync_last & prev_q;
  // Edges are ignored until the chain and prev hold real post-reset samples.
  assign set_bits  = qualified ? ((rise & rise_en_q) | (fall & fall_en_q)) : '0;
  assign clr_bits  = (wr && offset == OFF_STATUS) ? (wdata & wmask) : '0;

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = |status_q;

  always_comb begin
    rd_mux = '0;
    case (offset)
      OFF_OUT:    rd_mux = zext(out_q);
      OFF_IN:     rd_mux = zext(sync_last);
      OFF_DIR:    rd_mux = zext(dir_q);
      OFF_RISE:   rd_mux = zext(rise_en_q);
      OFF_FALL:   rd_mux = zext(fall_en_q);
      OFF_STATUS: rd_mux = zext(status_q);
      default:    rd_mux = '0;
    endcase
  end

  // Input synchroniser, edge history and post-reset qualification
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q   <= '0;
      qual_cnt <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_last;
      if (!qualified) qual_cnt <= qual_cnt + CNT_W'(1);
    end
  end

  // Bus response and register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.iomem_ready <= 1'b0;
      bus.iomem_rdata <= '0;
      out_q           <= '0;
      dir_q           <= '0;
      rise_en_q       <= '0;
      fall_en_q       <= '0;
      status_q        <= '0;
    end else begin
      bus.iomem_ready <= sel;
      bus.iomem_rdata <= sel ? rd_mux : '0;
      if (wr) begin
        case (offset)
          OFF_OUT:  out_q     <= merge(out_q, wdata, wmask);
          OFF_DIR:  dir_q     <= merge(dir_q, wdata, wmask);
          OFF_RISE: rise_en_q <= merge(rise_en_q, wdata, wmask);
          OFF_FALL: fall_en_q <= merge(fall_en_q, wdata, wmask);
          default:  ;
        endcase
      end
      // A capture in the same cycle as a clear keeps the bit set.
      status_q <= (status_q & ~clr_bits) | set_bits;
    end
  end

endmodule

// File: tb/tb_gpio_bank.sv
// Drives a WIDTH=8/SYNC_STAGES=2 and a WIDTH=32/SYNC_STAGES=3 gpio_bank with the same
// bus and pin stimulus, checking both against a behavioural model every cycle.
module tb_gpio_bank;
  logic        clk, reset;
  logic [31:0] pins;
  logic        valid;
  logic [3:0]  strb;
  logic [31:0] addr, wdata;

  logic [7:0]  out_a, oe_a;
  logic [31:0] out_b, oe_b;
  logic        irq_a, irq_b;

  int n_pass, n_total;

  gpio_bank_if bus_a ();
  gpio_bank_if bus_b ();

  assign bus_a.iomem_valid = valid;
  assign bus_a.iomem_wstrb = strb;
  assign bus_a.iomem_addr  = addr;
  assign bus_a.iomem_wdata = wdata;
  assign bus_b.iomem_valid = valid;
  assign bus_b.iomem_wstrb = strb;
  assign bus_b.iomem_addr  = addr;
  assign bus_b.iomem_wdata = wdata;

  gpio_bank #(.WIDTH(8), .BASE_ADDR(8'h03), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .gpio_in(pins[7:0]),
    .gpio_out(out_a), .gpio_oe(oe_a), .irq(irq_a)
  );

  gpio_bank #(.WIDTH(32), .BASE_ADDR(8'h03), .SYNC_STAGES(3)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .gpio_in(pins),
    .gpio_out(out_b), .gpio_oe(oe_b), .irq(irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: registers as plain words, the input path as a history of
  // pin samples per clock edge (newest first) rather than a shift register.
  logic [31:0] m_out [2], m_dir [2], m_ren [2], m_fen [2], m_stat [2], m_rdata [2];
  logic        m_ready [2];
  logic [31:0] hist [2][8];
  int          hcnt [2];

  function automatic logic [31:0] width_mask(input int d);
    return (d == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction

  function automatic int sync_depth(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_out[d] = 0; m_dir[d] = 0; m_ren[d] = 0; m_fen[d] = 0; m_stat[d] = 0;
      m_rdata[d] = 0; m_ready[d] = 1'b0; hcnt[d] = 0;
      for (int j = 0; j < 8; j++) hist[d][j] = 0;
    end
  endtask

  task automatic model_step(input int d);
    logic [31:0] wm, in_now, prev, bm, rd, set, clr;
    logic [7:0]  off;
    logic        sel, wr;
    int          s;
    wm     = width_mask(d);
    s      = sync_depth(d);
    // IN after edge n-1 is the pin sampled s-1 edges earlier; prev is one further back.
    in_now = (hcnt[d] >= s)     ? hist[d][s-1] : 32'h0;
    prev   = (hcnt[d] >= s + 1) ? hist[d][s]   : 32'h0;
    sel    = valid && !m_ready[d] && (addr[31:24] == 8'h03);
    off    = addr[7:0];
    wr     = sel && (strb != 4'b0000);
    bm     = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}} & wm;
    case (off)
      8'h00:   rd = m_out[d];
      8'h04:   rd = in_now;
      8'h08:   rd = m_dir[d];
      8'h0C:   rd = m_ren[d];
      8'h10:   rd = m_fen[d];
      8'h14:   rd = m_stat[d];
      default: rd = 32'h0;
    endcase
    set = (hcnt[d] > s) ? ((in_now & ~prev & m_ren[d]) | (~in_now & prev & m_fen[d])) : 32'h0;
    clr = (wr && off == 8'h14) ? (wdata & bm) : 32'h0;
    if (wr) begin
      case (off)
        8'h00:   m_out[d] = (m_out[d] & ~bm) | (wdata & bm);
        8'h08:   m_dir[d] = (m_dir[d] & ~bm) | (wdata & bm);
        8'h0C:   m_ren[d] = (m_ren[d] & ~bm) | (wdata & bm);
        8'h10:   m_fen[d] = (m_fen[d] & ~bm) | (wdata & bm);
        default: ;
      endcase
    end
    m_stat[d]  = (m_stat[d] & ~clr) | set;
    m_ready[d] = sel;
    m_rdata[d] = sel ? rd : 32'h0;
    for (int j = 7; j > 0; j--) hist[d][j] = hist[d][j-1];
    hist[d][0] = pins & wm;
    if (hcnt[d] < 8) hcnt[d]++;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_clear();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    check("out_a",   32'(out_a),   m_out[0]);
    check("oe_a",    32'(oe_a),    m_dir[0]);
    check("irq_a",   32'(irq_a),   32'(|m_stat[0]));
    check("ready_a", 32'(bus_a.iomem_ready), 32'(m_ready[0]));
    if (m_ready[0]) check("rdata_a", bus_a.iomem_rdata, m_rdata[0]);
    check("out_b",   out_b,        m_out[1]);
    check("oe_b",    oe_b,         m_dir[1]);
    check("irq_b",   32'(irq_b),   32'(|m_stat[1]));
    check("ready_b", 32'(bus_b.iomem_ready), 32'(m_ready[1]));
    if (m_ready[1]) check("rdata_b", bus_b.iomem_rdata, m_rdata[1]);
  end

  task automatic xact(input logic [7:0] off, input logic [3:0] s, input logic [31:0] d,
                      input logic [31:0] exp_a, input logic [31:0] exp_b, input string nm);
    valid = 1'b1;
    addr  = {8'h03, 16'h0000, off};
    strb  = s;
    wdata = d;
    @(posedge clk); #1;
    check({nm, "_ready_a"}, 32'(bus_a.iomem_ready), 32'h1);
    check({nm, "_ready_b"}, 32'(bus_b.iomem_ready), 32'h1);
    check({nm, "_rdata_a"}, bus_a.iomem_rdata, exp_a);
    check({nm, "_rdata_b"}, bus_b.iomem_rdata, exp_b);
    valid = 1'b0;
    strb  = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b1; pins = 32'h0000_00A5;
    valid = 1'b0; strb = 4'b0000; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Pins held high through reset must not raise edges.
    wait_cycles(10);
    check("rst_out_a", 32'(out_a), 32'h0);
    check("rst_oe_a",  32'(oe_a),  32'h0);
    check("rst_irq_a", 32'(irq_a), 32'h0);
    check("rst_irq_b", 32'(irq_b), 32'h0);
    xact(8'h04, 4'b0000, 32'h0, 32'h0000_00A5, 32'h0000_00A5, "rd_in");
    xact(8'h14, 4'b0000, 32'h0, 32'h0, 32'h0, "rd_status_idle");

    // Byte-strobed OUT write, readback, unmapped offset, foreign base address
    xact(8'h00, 4'b0001, 32'h1234_5678, 32'h0, 32'h0, "wr_out");
    check("wr_out_pin_a", 32'(out_a), 32'h78);
    check("wr_out_pin_b", out_b,      32'h78);
    xact(8'h00, 4'b0000, 32'h0, 32'h78, 32'h78, "rd_out");
    xact(8'h40, 4'b0000, 32'h0, 32'h0, 32'h0, "rd_unmapped");
    valid = 1'b1; addr = 32'h0400_0000;
    @(posedge clk); #1;
    check("other_base_ready", 32'(bus_a.iomem_ready), 32'h0);
    valid = 1'b0;
    wait_cycles(1);

    // DIR: byte lane beyond WIDTH=8 ignored on the narrow instance
    xact(8'h08, 4'b1111, 32'h0000_000F, 32'h0, 32'h0, "wr_dir");
    xact(8'h08, 4'b0010, 32'h0000_FFFF, 32'h0F, 32'h0F, "wr_dir_b1");
    check("dir_oe_a", 32'(oe_a), 32'h0F);
    check("dir_oe_b", oe_b,      32'h0000_FF0F);

    // Edge capture latency: rise on pin0, fall on pin1
    xact(8'h0C, 4'b1111, 32'h1, 32'h0, 32'h0, "wr_rise_en");
    xact(8'h10, 4'b1111, 32'h2, 32'h0, 32'h0, "wr_fall_en");
    pins = 32'h0000_00A6;
    wait_cycles(6);
    check("pre_edge_irq_a", 32'(irq_a), 32'h0);
    check("pre_edge_irq_b", 32'(irq_b), 32'h0);
    pins = 32'h0000_00A5;
    for (int k = 1; k <= 5; k++) begin
      wait_cycles(1);
      check("irq_lat_a", 32'(irq_a), 32'(k >= 3));
      check("irq_lat_b", 32'(irq_b), 32'(k >= 4));
    end
    xact(8'h14, 4'b0000, 32'h0, 32'h3, 32'h3, "rd_status_edges");
    pins = 32'h0000_00A1;
    wait_cycles(4);
    pins = 32'h0000_00A5;
    wait_cycles(4);
    xact(8'h14, 4'b0000, 32'h0, 32'h3, 32'h3, "rd_status_pin2");

    // Clear of bit 0 lands on the same edge as a new rising edge on the narrow instance
    pins = 32'h0000_00A4;
    wait_cycles(6);
    pins = 32'h0000_00A5;
    wait_cycles(2);
    xact(8'h14, 4'b0001, 32'h1, 32'h3, 32'h3, "w1c_vs_set");
    xact(8'h14, 4'b0000, 32'h0, 32'h3, 32'h3, "rd_status_setwins");
    check("irq_before_clr_a", 32'(irq_a), 32'h1);
    valid = 1'b1; addr = 32'h0300_0014; strb = 4'b0001; wdata = 32'h3;
    @(posedge clk); #1;
    check("irq_after_clr_a", 32'(irq_a), 32'h0);
    check("irq_after_clr_b", 32'(irq_b), 32'h0);
    check("clr_ready_a", 32'(bus_a.iomem_ready), 32'h1);
    valid = 1'b0; strb = 4'b0000;
    wait_cycles(1);
    xact(8'h14, 4'b0000, 32'h0, 32'h0, 32'h0, "rd_status_cleared");

    // Reset in the middle of a held write to OUT
    valid = 1'b1; addr = 32'h0300_0000; strb = 4'b1111; wdata = 32'hFF;
    #3 reset = 1'b1;
    #1;
    check("rst_mid_ready_a", 32'(bus_a.iomem_ready), 32'h0);
    check("rst_mid_out_a",   32'(out_a), 32'h0);
    wait_cycles(1);
    check("rst_hold_ready_a", 32'(bus_a.iomem_ready), 32'h0);
    check("rst_hold_ready_b", 32'(bus_b.iomem_ready), 32'h0);
    valid = 1'b0; strb = 4'b0000;
    @(posedge clk);
    #1 reset = 1'b0;
    wait_cycles(3);
    check("post_rst_out_a", 32'(out_a), 32'h0);
    check("post_rst_out_b", out_b,      32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
